countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//  Cascaded multi-digit down-counter (countdown timer). Mirrors the up-counting carry-chain
//  counters: digits decrement and pass a borrow upward instead of a carry. Loaded with a preset,
//  advanced by an external tick enable, stops at all-zero and pulses an expiry flag.
//  Sits beside the clock/display counters, sharing the same tick source and per-digit limits.
// PARAMETERS
//  WIDTH   4  bits per digit
//  DIGITS  3  number of cascaded digits; digit 0 is least significant
// PORTS
//  clk         in   1             clock; single clock domain, all state on posedge
//  rst         in   1             synchronous, active-high reset
//  tick        in   1             one-cycle decrement enable (e.g. 1 Hz strobe)
//  load        in   1             load load_value into count
//  load_value  in   DIGITS*WIDTH  preset; digit i = [i*WIDTH +: WIDTH]
//  digit_max   in   DIGITS*WIDTH  per-digit wrap value (e.g. 9 or 5); held stable while running
//  start       in   1             begin/resume counting
//  pause       in   1             suspend counting
//  clear       in   1             abort: count to 0, return to IDLE
//  count       out  DIGITS*WIDTH  current value, registered
//  running     out  1             high in RUNNING state
//  done        out  1             level: high in DONE state
//  expired     out  1             one-cycle pulse on entering DONE
// BEHAVIOUR
//  Reset: state=IDLE, count=0, running=0, done=0, expired=0.
//  Command priority per cycle: rst > clear > load > start > pause > tick.
//  States: IDLE, ARMED, RUNNING, PAUSED, DONE.
//   clear (any state)             -> IDLE, count=0, no expired pulse.
//   load in IDLE/ARMED/PAUSED/DONE -> ARMED; count=load_value with each digit clamped to its
//     digit_max (unsigned compare). load in RUNNING is ignored.
//   start in ARMED/PAUSED: count!=0 -> RUNNING; count==0 -> DONE with expired pulse.
//   start in IDLE/RUNNING/DONE ignored. pause in RUNNING -> PAUSED; elsewhere ignored.
//   tick only acts in RUNNING and only if no higher-priority command is active that cycle
//     (pause+tick same cycle: pause wins, no decrement).
//  Decrement (RUNNING, tick=1): borrow_in[0]=1. Per digit: if borrow_in==0 hold;
//   else if digit!=0 digit-1, borrow_out=0; else digit=digit_max[i], borrow_out=1.
//   borrow_in[i+1]=borrow_out[i]. Chain is combinational; single-cycle update of all digits.
//  Expiry: if the decremented value is all-zero, same edge: count=0, state=DONE, expired=1
//   for exactly that one cycle, done=1 until clear/load. Count never wraps below zero.
//  Latency: count reflects tick one cycle later; running/done are registered state decodes.
//  DONE holds count=0; further ticks/starts have no effect and produce no extra pulses.
//  rst mid-count: next cycle all outputs at reset values, no expired pulse.
// STRUCTURE
//  Package countdown_pkg: typedef enum logic [2:0] timer_state_e {IDLE,ARMED,RUNNING,PAUSED,DONE}.
//  Sub-module countdown_digit (WIDTH): one digit; inputs borrow_in, digit_max, load, load_value,
//   clr; outputs digit, borrow_out, is_zero. Top instantiates DIGITS via generate, chains borrow,
//   ANDs is_zero for the zero detect, and holds the state machine.
// TESTING (DIGITS=2, WIDTH=4, digit_max={5,9} i.e. 00..59)
//  reset -> count=0x00, running=0, done=0, expired=0; ticks in IDLE leave count=0x00.
//  load 0x10, start, 1 tick -> count=0x09 (digit0 wraps to 9, digit1 1->0), running=1.
//  load 0x02, start, 2 ticks -> 0x01 then 0x00; expired=1 for exactly one cycle, done=1 held;
//   3rd tick -> no change, no pulse.
//  load 0x7C -> clamps to 0x59; start, pause+tick same cycle -> count=0x59, state PAUSED;
//   start, tick -> 0x58.
//  load 0x00, start -> DONE, expired pulse one cycle; start again -> no pulse.
//  running at 0x30, clear with tick same cycle -> IDLE, 0x00, no expired; rst while RUNNING ->
//   all outputs reset next cycle; load while RUNNING ignored.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types and default geometry for the cascaded countdown timer.
// Imported by the timer top and its per-digit slice.
package countdown_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_DIGITS = 3;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    RUNNING,
    PAUSED,
    DONE
  } timer_state_e;

endpackage

// File: rtl/countdown_digit.sv
// One digit of the borrow chain.
// Computes the digit's next value from its current value.
module countdown_digit
  import countdown_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] digit_q,
  input  logic [WIDTH-1:0] digit_max,
  input  logic [WIDTH-1:0] load_value,
  input  logic             borrow_in,
  input  logic             load,
  input  logic             clr,
  output logic [WIDTH-1:0] digit,
  output logic             borrow_out,
  output logic             is_zero
);

  always_comb begin
    is_zero    = (digit_q == '0);
    borrow_out = borrow_in && is_zero;
    digit      = digit_q;
    if (clr) begin
      digit = '0;
    end else if (load) begin
      digit = (load_value > digit_max) ? digit_max : load_value;
    end else if (borrow_in) begin
      digit = is_zero ? digit_max : digit_q - 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Cascaded multi-digit countdown timer with load, start,
// pause, clear and a one-cycle expiry pulse.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    load,
  input  logic [DIGITS*WIDTH-1:0] load_value,
  input  logic [DIGITS*WIDTH-1:0] digit_max,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    clear,
  output logic [DIGITS*WIDTH-1:0] count,
  output logic                    running,
  output logic                    done,
  output logic                    expired
);

  timer_state_e state_q, state_d;
  logic [DIGITS*WIDTH-1:0] count_q, count_d, count_nx;
  logic expired_q, expired_d;

  logic [DIGITS-1:0] bin, bout, is_zero;
  logic ld_c, dec;
  logic all_zero, underflow;

  // Strict command priority: a higher command claims the
  // cycle even when the current state ignores it.
  always_comb begin
    ld_c = 1'b0;
    dec  = 1'b0;
    if (!clear) begin
      if (load) begin
        ld_c = (state_q != RUNNING);
      end else if (!start && !pause) begin
        dec = tick && (state_q == RUNNING);
      end
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    if (i == 0) begin : g_lsd
      assign bin[i] = dec;
    end else begin : g_up
      assign bin[i] = bout[i-1];
    end
    countdown_digit #(.WIDTH(WIDTH)) u_dig (
      .digit_q    (count_q[i*WIDTH +: WIDTH]),
      .digit_max  (digit_max[i*WIDTH +: WIDTH]),
      .load_value (load_value[i*WIDTH +: WIDTH]),
      .borrow_in  (bin[i]),
      .load       (ld_c),
      .clr        (clear),
      .digit      (count_d[i*WIDTH +: WIDTH]),
      .borrow_out (bout[i]),
      .is_zero    (is_zero[i])
    );
  end

  assign all_zero  = &is_zero;
  assign underflow = bout[DIGITS-1];

  always_comb begin
    state_d   = state_q;
    expired_d = 1'b0;
    count_nx  = underflow ? '0 : count_d;
    if (clear) begin
      state_d = IDLE;
    end else if (load) begin
      if (state_q != RUNNING) state_d = ARMED;
    end else if (start) begin
      if (state_q == ARMED || state_q == PAUSED) begin
        state_d   = all_zero ? DONE : RUNNING;
        expired_d = all_zero;
      end
    end else if (pause) begin
      if (state_q == RUNNING) state_d = PAUSED;
    end else if (dec) begin
      if (count_nx == '0) begin
        state_d   = DONE;
        expired_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_nx;
      expired_q <= expired_d;
    end
  end

  assign count   = count_q;
  assign running = (state_q == RUNNING);
  assign done    = (state_q == DONE);
  assign expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed scoreboard bench for a 2-digit 00..59 countdown.
// Each vector pushes its expected outputs; they are popped after the edge.
module tb_countdown_timer;

  localparam int W = 4;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst, tick, load, start, pause, clear;
  logic [D*W-1:0] load_value, digit_max, count;
  logic         running, done, expired;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string        tag;
    logic [7:0]   cnt;
    logic         run;
    logic         dn;
    logic         exp;
  } exp_t;

  exp_t sb[$];

  countdown_timer #(.WIDTH(W), .DIGITS(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .load       (load),
    .load_value (load_value),
    .digit_max  (digit_max),
    .start      (start),
    .pause      (pause),
    .clear      (clear),
    .count      (count),
    .running    (running),
    .done       (done),
    .expired    (expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // cmd bits: {rst, clear, load, start, pause, tick}
  task automatic step(input string tag, input logic [5:0] cmd,
                      input logic [7:0] lv, input logic [7:0] ecnt,
                      input logic erun, input logic edn,
                      input logic eexp);
    exp_t e;
    {rst, clear, load, start, pause, tick} = cmd;
    load_value = lv;
    e.tag = tag;
    e.cnt = ecnt;
    e.run = erun;
    e.dn  = edn;
    e.exp = eexp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".cnt"}, count, e.cnt);
    chk({e.tag, ".run"}, {7'd0, running}, {7'd0, e.run});
    chk({e.tag, ".done"}, {7'd0, done}, {7'd0, e.dn});
    chk({e.tag, ".exp"}, {7'd0, expired}, {7'd0, e.exp});
  endtask

  localparam logic [5:0] NOP = 6'b000000;
  localparam logic [5:0] RST = 6'b100000;
  localparam logic [5:0] CLR = 6'b010000;
  localparam logic [5:0] LD  = 6'b001000;
  localparam logic [5:0] ST  = 6'b000100;
  localparam logic [5:0] PS  = 6'b000010;
  localparam logic [5:0] TK  = 6'b000001;

  initial begin
    {rst, clear, load, start, pause, tick} = '0;
    load_value = '0;
    digit_max  = 8'h59;
    #2;
    step("reset",      RST,      8'h00, 8'h00, 0, 0, 0);
    step("idle_tick",  TK,       8'h00, 8'h00, 0, 0, 0);
    step("ld10",       LD,       8'h10, 8'h10, 0, 0, 0);
    step("st10",       ST,       8'h00, 8'h10, 1, 0, 0);
    step("tk_wrap",    TK,       8'h00, 8'h09, 1, 0, 0);
    step("ld_in_run",  LD,       8'h02, 8'h09, 1, 0, 0);
    step("pause09",    PS,       8'h00, 8'h09, 0, 0, 0);
    step("ld02",       LD,       8'h02, 8'h02, 0, 0, 0);
    step("st02",       ST,       8'h00, 8'h02, 1, 0, 0);
    step("tk01",       TK,       8'h00, 8'h01, 1, 0, 0);
    step("tk00",       TK,       8'h00, 8'h00, 0, 1, 1);
    step("tk_done",    TK,       8'h00, 8'h00, 0, 1, 0);
    step("st_done",    ST,       8'h00, 8'h00, 0, 1, 0);
    step("ld7c",       LD,       8'h7C, 8'h59, 0, 0, 0);
    step("st59",       ST,       8'h00, 8'h59, 1, 0, 0);
    step("ps_tk",      PS | TK,  8'h00, 8'h59, 0, 0, 0);
    step("resume",     ST,       8'h00, 8'h59, 1, 0, 0);
    step("tk58",       TK,       8'h00, 8'h58, 1, 0, 0);
    step("clr58",      CLR,      8'h00, 8'h00, 0, 0, 0);
    step("ld00",       LD,       8'h00, 8'h00, 0, 0, 0);
    step("st00",       ST,       8'h00, 8'h00, 0, 1, 1);
    step("st00_again", ST,       8'h00, 8'h00, 0, 1, 0);
    step("hold_done",  NOP,      8'h00, 8'h00, 0, 1, 0);
    step("ld30",       LD,       8'h30, 8'h30, 0, 0, 0);
    step("st30",       ST,       8'h00, 8'h30, 1, 0, 0);
    step("clr_tk",     CLR | TK, 8'h00, 8'h00, 0, 0, 0);
    step("idle_tk2",   TK,       8'h00, 8'h00, 0, 0, 0);
    step("ld0f",       LD,       8'h0F, 8'h09, 0, 0, 0);
    step("st_tk",      ST | TK,  8'h00, 8'h09, 1, 0, 0);
    step("tk08",       TK,       8'h00, 8'h08, 1, 0, 0);
    step("ld30b",      CLR,      8'h00, 8'h00, 0, 0, 0);
    step("ld30c",      LD,       8'h30, 8'h30, 0, 0, 0);
    step("st30b",      ST,       8'h00, 8'h30, 1, 0, 0);
    step("tk29",       TK,       8'h00, 8'h29, 1, 0, 0);
    step("rst_run",    RST | TK, 8'h00, 8'h00, 0, 0, 0);
    step("post_rst",   TK,       8'h00, 8'h00, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
